// File: rtl/axis_sdp_fifo_ctrl.sv
// axis_sdp_fifo_ctrl: AXI-Stream FIFO controller around an external simple dual-port RAM
// with a registered read port, plus a 2-entry output queue that absorbs the read latency.
module axis_sdp_fifo_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic [DATA_W-1:0]          s_axis_tdata,
    input  logic                       s_axis_tlast,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic [DATA_W-1:0]          m_axis_tdata,
    output logic                       m_axis_tlast,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       ram_ena,
    output logic                       ram_wea,
    output logic [$clog2(DEPTH)-1:0]   ram_addra,
    output logic [DATA_W:0]            ram_dia,
    output logic                       ram_enb,
    output logic [$clog2(DEPTH)-1:0]   ram_addrb,
    input  logic [DATA_W:0]            ram_dob,
    output logic [$clog2(DEPTH)+1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = AW + 2;

    logic [PW-1:0]   wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, level, level_n;
    logic [1:0]      out_cnt, out_cnt_n;
    logic [2:0]      occ;
    logic [DATA_W:0] head, tail;
    logic [CW-1:0]   count_r;
    logic            pend, ready_r, wr, rd, pop, push, push_head;

    always_comb begin
        pop       = m_axis_tvalid & m_axis_tready;
        wr        = s_axis_tvalid & ready_r & ~clear;
        level     = wr_ptr - rd_ptr;
        // queue slots already claimed once this cycle's pop is accounted for
        occ       = 3'(out_cnt) + 3'(pend) - 3'(pop);
        rd        = (level != '0) & ~clear & (occ < 3'd2);
        push      = pend & ~clear;
        push_head = (out_cnt == 2'd0) | ((out_cnt == 2'd1) & pop);
        wr_ptr_n  = clear ? '0 : wr_ptr + PW'(wr);
        rd_ptr_n  = clear ? '0 : rd_ptr + PW'(rd);
        out_cnt_n = clear ? '0 : out_cnt - 2'(pop) + 2'(push);
        level_n   = wr_ptr_n - rd_ptr_n;
    end

    assign s_axis_tready = ready_r;
    assign m_axis_tvalid = out_cnt != 2'd0;
    assign {m_axis_tlast, m_axis_tdata} = head;
    assign ram_ena   = wr;
    assign ram_wea   = wr;
    assign ram_addra = wr_ptr[AW-1:0];
    assign ram_dia   = wr ? {s_axis_tlast, s_axis_tdata} : '0;
    assign ram_enb   = rd;
    assign ram_addrb = rd_ptr[AW-1:0];
    assign count     = count_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pend    <= 1'b0;
            out_cnt <= '0;
            ready_r <= 1'b0;
            count_r <= '0;
            head    <= '0;
            tail    <= '0;
        end else begin
            wr_ptr  <= wr_ptr_n;
            rd_ptr  <= rd_ptr_n;
            pend    <= rd;
            out_cnt <= out_cnt_n;
            ready_r <= level_n < PW'(DEPTH);
            count_r <= CW'(level_n) + CW'(rd) + CW'(out_cnt_n);
            if (!clear) begin
                if (pop) head <= tail;
                if (push && push_head) head <= ram_dob;
                if (push && !push_head) tail <= ram_dob;
            end
        end
    end
endmodule
